serial_frame_rx: RTL

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

---
 rtl/serial_frame_rx.sv | 128 ++++++++++++
 1 files changed

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Optional parity stage is compiled in with `define SERIAL_FRAME_RX_PARITY_EN.
module serial_frame_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             frame_err,
    output logic             parity_err,
    output logic             busy
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             par_bad;

`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic pbad_q, pbad_d;
    logic perr_q, perr_d;

    assign par_bad    = pbad_q;
    assign parity_err = perr_q;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            pbad_q  <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            pbad_q  <= pbad_d;
            perr_q  <= perr_d;
`endif
        end
    end

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        pbad_d  = pbad_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!sin) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                shift_d[cnt_q] = sin;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef SERIAL_FRAME_RX_PARITY_EN
            PARITY: begin
                // Even parity: the received bit must equal the XOR of the data bits.
                pbad_d  = sin ^ (^shift_q);
                state_d = STOP;
            end
`endif
            STOP: begin
                state_d = IDLE;
                ferr_d  = !sin;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                perr_d  = pbad_q;
`endif
                if (sin && !par_bad) begin
                    dout_d  = shift_q;
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != IDLE);

endmodule
